// File: rtl/fib_step_ctrl_if.sv
// Button, overflow and strobe signals between the step controller and the
// fibonacci generator / board pins.
interface fib_step_ctrl_if;
  logic but_step;
  logic but_mode;
  logic ovf;
  logic step;
  logic clear;
  logic auto_mode;
  logic halted;

  modport master (
    input  but_step, but_mode, ovf,
    output step, clear, auto_mode, halted
  );

  modport slave (
    output but_step, but_mode, ovf,
    input  step, clear, auto_mode, halted
  );
endinterface

// File: rtl/fib_step_ctrl.sv
// Button debounce and step/clear sequencing for the fibonacci generator.
// Optional macro FIB_STEP_SPEED_EN: step press in AUTO toggles a 4x speed bit.
//
// state  | meaning
// MANUAL | step press advances one term (or clears when ovf is set)
// AUTO   | prescaler issues a step every period, ovf halts
// HALT   | overflow seen, waiting for a press to clear and restart
module fib_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_DIV        = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  fib_step_ctrl_if.master bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(STEP_DIV);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HALT   = 2'd2
  } state_t;

  // index 0: step button, index 1: mode button
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         db;
  logic [1:0]         db_q;
  logic [1:0][DW-1:0] cnt;
  logic [1:0]         press;
  logic               step_ev;
  logic               mode_ev;

  state_t             state;
  logic [PW-1:0]      presc;
  logic [PW-1:0]      presc_last;

  assign raw = {bus.but_mode, bus.but_step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Mode wins over a coincident step press.
  assign press   = db & ~db_q;
  assign mode_ev = press[1];
  assign step_ev = press[0] & ~press[1];

`ifdef FIB_STEP_SPEED_EN
  logic speed;
  assign presc_last = speed ? PW'(STEP_DIV / 4 - 1) : PW'(STEP_DIV - 1);
`else
  assign presc_last = PW'(STEP_DIV - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MANUAL;
      presc         <= '0;
      bus.step      <= 1'b0;
      bus.clear     <= 1'b0;
      bus.auto_mode <= 1'b0;
      bus.halted    <= 1'b0;
`ifdef FIB_STEP_SPEED_EN
      speed         <= 1'b0;
`endif
    end else begin
      bus.step  <= 1'b0;
      bus.clear <= 1'b0;
      case (state)
        MANUAL: begin
          presc <= '0;
          if (mode_ev) begin
            state         <= AUTO;
            bus.auto_mode <= 1'b1;
          end else if (step_ev) begin
            if (bus.ovf) bus.clear <= 1'b1;
            else         bus.step  <= 1'b1;
          end
        end
        AUTO: begin
          if (bus.ovf) begin
            state         <= HALT;
            presc         <= '0;
            bus.auto_mode <= 1'b0;
            bus.halted    <= 1'b1;
`ifdef FIB_STEP_SPEED_EN
            speed         <= 1'b0;
`endif
          end else if (mode_ev) begin
            state         <= MANUAL;
            presc         <= '0;
            bus.auto_mode <= 1'b0;
`ifdef FIB_STEP_SPEED_EN
            speed         <= 1'b0;
`endif
          end else if (step_ev) begin
            presc <= '0;
`ifdef FIB_STEP_SPEED_EN
            speed <= ~speed;
`else
            bus.clear <= 1'b1;
`endif
          end else if (presc >= presc_last) begin
            // >= so a speed change never leaves the count above the new wrap
            presc    <= '0;
            bus.step <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        HALT: begin
          presc <= '0;
          if (mode_ev) begin
            state         <= AUTO;
            bus.clear     <= 1'b1;
            bus.auto_mode <= 1'b1;
            bus.halted    <= 1'b0;
          end else if (step_ev) begin
            state      <= MANUAL;
            bus.clear  <= 1'b1;
            bus.halted <= 1'b0;
          end
        end
        default: begin
          state         <= MANUAL;
          presc         <= '0;
          bus.auto_mode <= 1'b0;
          bus.halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_step_ctrl.sv
// Scoreboard bench for fib_step_ctrl: expected strobes (kind, cycle) are queued
// when buttons are driven and matched against every step/clear pulse seen.
module tb_fib_step_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  fib_step_ctrl_if bus ();

  fib_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .STEP_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit clr;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic push(input bit clr, input int at);
    exp_t e;
    e.clr = clr;
    e.at  = at;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.step || bus.clear)) begin
      chk("exclusive", int'(bus.step & bus.clear), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", int'({bus.step, bus.clear}), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", int'(bus.clear), int'(mon_e.clr));
        chk("strobe_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    bus.but_step = 1'b0;
    bus.but_mode = 1'b0;
    bus.ovf      = 1'b0;
    rst_n        = 1'b0;
    tick(3);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_clear", int'(bus.clear), 0);
    chk("rst_auto", int'(bus.auto_mode), 0);
    chk("rst_halted", int'(bus.halted), 0);
    rst_n = 1'b1;
    tick(2);

    // bounce: never stable for DEB cycles
    for (int i = 0; i < 10; i++) begin
      bus.but_step = ~bus.but_step;
      tick(2);
    end
    bus.but_step = 1'b0;
    tick(12);
    chk("bounce_queue", sb.size(), 0);

    // manual single step
    t = cyc;
    push(1'b0, t + 7);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    tick(12);
    chk("manual_queue", sb.size(), 0);
    chk("manual_auto", int'(bus.auto_mode), 0);

    // auto run, then overflow on a wrap cycle
    t = cyc;
    for (int i = 0; i < 10; i++) push(1'b0, t + 15 + 8 * i);
    bus.but_mode = 1'b1;
    tick(10);
    bus.but_mode = 1'b0;
    chk("auto_on", int'(bus.auto_mode), 1);
    wait_until(t + 88);
    chk("auto_queue", sb.size(), 0);
    wait_until(t + 94);
    bus.ovf = 1'b1;
    tick(1);
    chk("ovf_halted", int'(bus.halted), 1);
    chk("ovf_auto", int'(bus.auto_mode), 0);
    tick(20);
    bus.ovf = 1'b0;
    tick(2);
    t = cyc;
    push(1'b1, t + 7);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    chk("halt_exit_halted", int'(bus.halted), 0);
    chk("halt_exit_auto", int'(bus.auto_mode), 0);
    tick(10);
    chk("halt_queue", sb.size(), 0);

    // both buttons on the same debounced cycle: mode wins
    t = cyc;
    bus.but_step = 1'b1;
    bus.but_mode = 1'b1;
    tick(10);
    chk("both_auto", int'(bus.auto_mode), 1);
    bus.ovf = 1'b1;
    bus.but_step = 1'b0;
    bus.but_mode = 1'b0;
    tick(1);
    chk("both_halted", int'(bus.halted), 1);
    bus.ovf = 1'b0;
    tick(10);
    t = cyc;
    push(1'b1, t + 7);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    tick(10);
    chk("both_exit_auto", int'(bus.auto_mode), 0);
    chk("both_exit_halted", int'(bus.halted), 0);

    // step press with ovf in MANUAL clears
    bus.ovf = 1'b1;
    t = cyc;
    push(1'b1, t + 7);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    tick(10);
    bus.ovf = 1'b0;
    chk("manual_ovf_queue", sb.size(), 0);

    // reset in AUTO at prescaler 5
    t = cyc;
    bus.but_mode = 1'b1;
    tick(10);
    bus.but_mode = 1'b0;
    chk("pre_rst_auto", int'(bus.auto_mode), 1);
    wait_until(t + 12);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({bus.step, bus.clear, bus.auto_mode, bus.halted}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(16);
    chk("post_rst_auto", int'(bus.auto_mode), 0);
    chk("post_rst_queue", sb.size(), 0);

`ifdef FIB_STEP_SPEED_EN
    t = cyc;
    bus.but_mode = 1'b1;
    tick(10);
    bus.but_mode = 1'b0;
    push(1'b0, t + 15);
    for (int i = 0; i < 4; i++) push(1'b0, t + 19 + 2 * i);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    wait_until(t + 25);
    bus.ovf = 1'b1;
    tick(1);
    chk("speed_halted", int'(bus.halted), 1);
    bus.ovf = 1'b0;
    tick(10);
    t = cyc;
    push(1'b1, t + 7);
    bus.but_step = 1'b1;
    tick(10);
    bus.but_step = 1'b0;
    tick(10);
    chk("speed_queue", sb.size(), 0);
`endif

    chk("final_queue", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
